// File: rtl/numlock_button_conditioner_pkg.sv
// Shared types and default timing for the number-lock button conditioner.
// Optional feature macro: NUMLOCK_AUTOREPEAT_EN (auto-repeat while a button is held).
package numlock_button_conditioner_pkg;

    localparam int unsigned DEF_DEB_COUNT    = 500000;
    localparam int unsigned DEF_REPEAT_COUNT = 25000000;
    localparam int unsigned DEF_CNT_W        = 25;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WQ_PRS = 3'd1,
        PULSE  = 3'd2,
        HELD   = 3'd3,
        WQ_REL = 3'd4
    } ch_state_t;

endpackage

// File: rtl/numlock_button_conditioner_if.sv
// Button-side bundle: raw button inputs and conditioned pulse/level outputs.
interface numlock_button_conditioner_if;

    logic btn_u_raw;
    logic btn_z_raw;
    logic u;
    logic z;
    logic u_db;
    logic z_db;

    modport master (
        output btn_u_raw, btn_z_raw,
        input  u, z, u_db, z_db
    );

    modport slave (
        input  btn_u_raw, btn_z_raw,
        output u, z, u_db, z_db
    );

endinterface

// File: rtl/numlock_button_conditioner_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with counter, registered pulse/level.
// NUMLOCK_AUTOREPEAT_EN enables periodic pulses while the button stays held.
module numlock_debounce_ch
    import numlock_button_conditioner_pkg::*;
#(
    parameter int unsigned DEB_COUNT    = DEF_DEB_COUNT,
    parameter int unsigned REPEAT_COUNT = DEF_REPEAT_COUNT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic Clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse,
    output logic db
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_COUNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_COUNT - 1);

    logic             s1, btn_s;
    ch_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pulse_n, db_n;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn_raw;
            btn_s <= s1;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            db    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pulse <= pulse_n;
            db    <= db_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) state_n = WQ_PRS;
            end
            WQ_PRS: begin
                if (!btn_s)               state_n = IDLE;
                else if (cnt == DEB_LAST) state_n = PULSE;
                else                      cnt_n   = cnt + 1'b1;
            end
            PULSE: begin
                state_n = HELD;
            end
            HELD: begin
                if (!btn_s) begin
                    state_n = WQ_REL;
                end else if (cnt == REP_LAST) begin
`ifdef NUMLOCK_AUTOREPEAT_EN
                    pulse_n = 1'b1;
                    cnt_n   = '0;
`else
                    cnt_n   = cnt;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WQ_REL: begin
                if (btn_s)                state_n = HELD;
                else if (cnt == DEB_LAST) state_n = IDLE;
                else                      cnt_n   = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        if (state_n != state) cnt_n = '0;
        if (state_n == PULSE) pulse_n = 1'b1;
        db_n = (state_n == PULSE) || (state_n == HELD) || (state_n == WQ_REL);
    end

endmodule

// File: rtl/numlock_button_conditioner.sv
// Conditions the U and Z push-buttons into single-cycle press pulses for the lock FSM.
// NUMLOCK_AUTOREPEAT_EN enables auto-repeat pulses on held buttons.
module numlock_button_conditioner
    import numlock_button_conditioner_pkg::*;
#(
    parameter int unsigned DEB_COUNT    = DEF_DEB_COUNT,
    parameter int unsigned REPEAT_COUNT = DEF_REPEAT_COUNT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                          Clk,
    input  logic                          reset,
    numlock_button_conditioner_if.slave   btn
);

    numlock_debounce_ch #(
        .DEB_COUNT    (DEB_COUNT),
        .REPEAT_COUNT (REPEAT_COUNT),
        .CNT_W        (CNT_W)
    ) u_ch_u (
        .Clk     (Clk),
        .reset   (reset),
        .btn_raw (btn.btn_u_raw),
        .pulse   (btn.u),
        .db      (btn.u_db)
    );

    numlock_debounce_ch #(
        .DEB_COUNT    (DEB_COUNT),
        .REPEAT_COUNT (REPEAT_COUNT),
        .CNT_W        (CNT_W)
    ) u_ch_z (
        .Clk     (Clk),
        .reset   (reset),
        .btn_raw (btn.btn_z_raw),
        .pulse   (btn.z),
        .db      (btn.z_db)
    );

endmodule

// File: tb/tb_numlock_button_conditioner.sv
// Scoreboard bench for numlock_button_conditioner with DEB_COUNT=4, REPEAT_COUNT=10, CNT_W=4.
module tb_numlock_button_conditioner;

    typedef struct {
        int unsigned cyc;
        logic        u;
        logic        z;
    } exp_t;

    logic        Clk;
    logic        reset;
    int unsigned cyc;
    int unsigned checks;
    int unsigned failures;
    exp_t        sb[$];

    numlock_button_conditioner_if bus ();

    numlock_button_conditioner #(
        .DEB_COUNT    (4),
        .REPEAT_COUNT (10),
        .CNT_W        (4)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .btn   (bus.slave)
    );

    initial Clk = 1'b0;
    always #100 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_u"},    bus.u,    1'b0);
        chk({name, "_z"},    bus.z,    1'b0);
        chk({name, "_u_db"}, bus.u_db, 1'b0);
        chk({name, "_z_db"}, bus.z_db, 1'b0);
    endtask

    task automatic expect_pulse(input int unsigned at, input logic eu, input logic ez);
        exp_t e;
        e.cyc = at;
        e.u   = eu;
        e.z   = ez;
        sb.push_back(e);
    endtask

    // Monitor: every pulse the DUT presents must match the head of the scoreboard.
    always @(negedge Clk) begin
        exp_t e;
        if (reset && (bus.u || bus.z)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d actual u=%b z=%b required none",
                         cyc, bus.u, bus.z);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.u !== bus.u || e.z !== bus.z) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d u=%b z=%b required cyc=%0d u=%b z=%b",
                             cyc, bus.u, bus.z, e.cyc, e.u, e.z);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned c;
        int unsigned d;
        logic [6:0]  rel_pat;

        checks   = 0;
        failures = 0;

        // 1: reset held with toggling buttons, then released with buttons idle
        reset = 1'b0;
        bus.btn_u_raw = 1'b0;
        bus.btn_z_raw = 1'b0;
        #20 bus.btn_u_raw = 1'b1;
        #30 chk_all_zero("rst_a");
        bus.btn_z_raw = 1'b1;
        #40 chk_all_zero("rst_b");
        bus.btn_u_raw = 1'b0;
        #20 chk_all_zero("rst_c");
        #10 reset = 1'b1;
        bus.btn_u_raw = 1'b0;
        bus.btn_z_raw = 1'b0;
        repeat (10) @(negedge Clk);
        chk_all_zero("post_rst");

        // 2: clean U press held 20 cycles
        c = cyc;
        bus.btn_u_raw = 1'b1;
        expect_pulse(c + 7, 1'b1, 1'b0);
        repeat (6) @(negedge Clk);
        chk("t2_udb_before", bus.u_db, 1'b0);
        @(negedge Clk);
        chk("t2_udb_at_pulse", bus.u_db, 1'b1);
        chk("t2_zdb", bus.z_db, 1'b0);
        repeat (13) @(negedge Clk);
        bus.btn_u_raw = 1'b0;
        repeat (10) @(negedge Clk);
        chk("t2_udb_released", bus.u_db, 1'b0);

        // 3: short Z glitches are rejected
        for (int i = 0; i < 3; i++) begin
            bus.btn_z_raw = 1'b1;
            repeat (2) @(negedge Clk);
            bus.btn_z_raw = 1'b0;
            repeat (3) @(negedge Clk);
            chk("t3_zdb", bus.z_db, 1'b0);
        end
        repeat (5) @(negedge Clk);

        // 4: bouncy U release yields one pulse, level drops after stable low
        c = cyc;
        bus.btn_u_raw = 1'b1;
        expect_pulse(c + 7, 1'b1, 1'b0);
        repeat (12) @(negedge Clk);
        d = cyc;
        rel_pat = 7'b0000010;
        for (int i = 0; i < 7; i++) begin
            bus.btn_u_raw = rel_pat[i];
            @(negedge Clk);
        end
        chk("t4_udb_d7", bus.u_db, 1'b1);
        @(negedge Clk);
        chk("t4_udb_d8", bus.u_db, 1'b1);
        @(negedge Clk);
        chk("t4_udb_d9", bus.u_db, 1'b0);
        if (cyc != d + 9) begin
            checks++;
            failures++;
            $display("FAIL t4_cycle actual=%0d required=%0d", cyc, d + 9);
        end
        repeat (5) @(negedge Clk);

        // 5: simultaneous U and Z presses
        c = cyc;
        bus.btn_u_raw = 1'b1;
        bus.btn_z_raw = 1'b1;
        expect_pulse(c + 7, 1'b1, 1'b1);
        repeat (10) @(negedge Clk);
        chk("t5_udb", bus.u_db, 1'b1);
        chk("t5_zdb", bus.z_db, 1'b1);
        bus.btn_u_raw = 1'b0;
        bus.btn_z_raw = 1'b0;
        repeat (10) @(negedge Clk);
        chk("t5_udb_rel", bus.u_db, 1'b0);
        chk("t5_zdb_rel", bus.z_db, 1'b0);

        // 6: reset mid-debounce, then a fresh full debounce with U still held
        c = cyc;
        bus.btn_u_raw = 1'b1;
        repeat (5) @(negedge Clk);
        reset = 1'b0;
        #1 chk("t6_u_in_rst", bus.u, 1'b0);
        chk("t6_udb_in_rst", bus.u_db, 1'b0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        d = cyc;
        expect_pulse(d + 7, 1'b1, 1'b0);
        repeat (6) @(negedge Clk);
        chk("t6_udb_before", bus.u_db, 1'b0);
        repeat (4) @(negedge Clk);
        bus.btn_u_raw = 1'b0;
        repeat (10) @(negedge Clk);

        // 7: U held 40 cycles
        c = cyc;
        bus.btn_u_raw = 1'b1;
        expect_pulse(c + 7, 1'b1, 1'b0);
`ifdef NUMLOCK_AUTOREPEAT_EN
        expect_pulse(c + 18, 1'b1, 1'b0);
        expect_pulse(c + 28, 1'b1, 1'b0);
        expect_pulse(c + 38, 1'b1, 1'b0);
`endif
        repeat (40) @(negedge Clk);
        chk("t7_udb_held", bus.u_db, 1'b1);
        bus.btn_u_raw = 1'b0;
        repeat (15) @(negedge Clk);
        chk("t7_udb_rel", bus.u_db, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL pending_pulses actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
